// File: rtl/vc_demux4_buf.sv
// rtl/vc_demux4_buf.sv - buffered 1-to-4 val/rdy demux, one-entry register per output
// Optional: define VC_DEMUX_SCRUB_EN to zero payload and domain when an output drains.
module vc_demux4_buf #(
  parameter int p_nbits = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_val,
  output logic                 in_rdy,
  input  logic                 in_domain,
  input  logic [1:0]           in_sel,
  input  logic [p_nbits-1:0]   in_msg,
  output logic [3:0]           out_val,
  input  logic [3:0]           out_rdy,
  output logic [3:0]           out_domain,
  output logic [4*p_nbits-1:0] out_msg
);

  logic [3:0]         full_q;
  logic [3:0]         dom_q;
  logic [p_nbits-1:0] data_q [4];
  logic [3:0]         deq;
  logic               enq;

  // A full buffer can still accept if it is draining this same cycle.
  always_comb begin
    deq    = full_q & out_rdy;
    in_rdy = !full_q[in_sel] || out_rdy[in_sel];
    enq    = in_val && in_rdy;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= '0;
      dom_q  <= '0;
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (enq && (in_sel == 2'(i))) begin
          full_q[i] <= 1'b1;
          dom_q[i]  <= in_domain;
          data_q[i] <= in_msg;
        end else if (deq[i]) begin
          full_q[i] <= 1'b0;
`ifdef VC_DEMUX_SCRUB_EN
          dom_q[i]  <= 1'b0;
          data_q[i] <= '0;
`endif
        end
      end
    end
  end

  assign out_val    = full_q;
  assign out_domain = dom_q;

  for (genvar g = 0; g < 4; g++) begin : g_out
    assign out_msg[g*p_nbits +: p_nbits] = data_q[g];
  end

endmodule

// File: tb/tb_vc_demux4_buf.sv
// tb/tb_vc_demux4_buf.sv - self-checking bench for vc_demux4_buf (honours VC_DEMUX_SCRUB_EN)
module tb_vc_demux4_buf;
  localparam int NB = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            in_val;
  logic            in_rdy;
  logic            in_domain;
  logic [1:0]      in_sel;
  logic [NB-1:0]   in_msg;
  logic [3:0]      out_val;
  logic [3:0]      out_rdy;
  logic [3:0]      out_domain;
  logic [4*NB-1:0] out_msg;

  always #5 clk = ~clk;

  vc_demux4_buf #(.p_nbits(NB)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_val(in_val), .in_rdy(in_rdy), .in_domain(in_domain), .in_sel(in_sel), .in_msg(in_msg),
    .out_val(out_val), .out_rdy(out_rdy), .out_domain(out_domain), .out_msg(out_msg)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [NB-1:0] sl(input int i);
    return out_msg[i*NB +: NB];
  endfunction

  // Reference: one ordered list of in-flight messages tagged with their port; each port holds at most one.
  typedef struct { int port; logic dom; logic [NB-1:0] data; } ent_t;
  ent_t pend[$];

  function automatic int head(input int p);
    foreach (pend[k]) if (pend[k].port == p) return k;
    return -1;
  endfunction

  function automatic logic m_rdy(input logic [1:0] s);
    return (head(int'(s)) < 0) || out_rdy[s];
  endfunction

  task automatic check_model();
    chk("model_in_rdy", {63'd0, in_rdy}, {63'd0, m_rdy(in_sel)});
    for (int i = 0; i < 4; i++) begin
      int h;
      h = head(i);
      chk($sformatf("model_val%0d", i), {63'd0, out_val[i]}, {63'd0, h >= 0});
      if (h >= 0) begin
        chk($sformatf("model_msg%0d", i), {32'd0, sl(i)}, {32'd0, pend[h].data});
        chk($sformatf("model_dom%0d", i), {63'd0, out_domain[i]}, {63'd0, pend[h].dom});
      end
`ifdef VC_DEMUX_SCRUB_EN
      else begin
        chk($sformatf("scrub_msg%0d", i), {32'd0, sl(i)}, 64'd0);
        chk($sformatf("scrub_dom%0d", i), {63'd0, out_domain[i]}, 64'd0);
      end
`endif
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic d,
                       input logic [NB-1:0] m, input logic [3:0] r);
    in_val = v; in_sel = s; in_domain = d; in_msg = m; out_rdy = r;
    #1;
  endtask

  task automatic tick();
    logic acc;
    ent_t e;
    acc = in_val && m_rdy(in_sel);
    @(posedge clk);
    if (reset_n) begin
      for (int i = 0; i < 4; i++) begin
        int h;
        h = head(i);
        if (h >= 0 && out_rdy[i]) pend.delete(h);
      end
      if (acc) begin
        e.port = int'(in_sel); e.dom = in_domain; e.data = in_msg;
        pend.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic v; logic [1:0] s; logic d; logic [NB-1:0] m; logic [3:0] r;
    logic exp_rdy; logic [3:0] exp_val;
    logic chk_en; logic [1:0] chk_i; logic [NB-1:0] exp_msg; logic exp_dom;
  } vec_t;
  vec_t tbl[12];

  initial begin
    // routing with all outputs ready, then head-of-line isolation on output 0
    tbl[0]  = '{1'b1, 2'd0, 1'b0, 32'hA0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0,  1'b0};
    tbl[1]  = '{1'b1, 2'd1, 1'b1, 32'hA1, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0, 1'b0};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'hA2, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1, 1'b1};
    tbl[3]  = '{1'b1, 2'd3, 1'b1, 32'hA3, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 32'h0,  4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3, 1'b1};
    tbl[5]  = '{1'b1, 2'd0, 1'b0, 32'h11, 4'hE, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0,  1'b0};
    tbl[6]  = '{1'b1, 2'd0, 1'b0, 32'h22, 4'hE, 1'b0, 4'b0001, 1'b1, 2'd0, 32'h11, 1'b0};
    tbl[7]  = '{1'b1, 2'd2, 1'b1, 32'h33, 4'hE, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h11, 1'b0};
    tbl[8]  = '{1'b1, 2'd0, 1'b0, 32'h22, 4'hE, 1'b0, 4'b0101, 1'b1, 2'd2, 32'h33, 1'b1};
    tbl[9]  = '{1'b1, 2'd0, 1'b0, 32'h22, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h11, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 1'b0, 32'h0,  4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h22, 1'b0};
    tbl[11] = '{1'b0, 2'd0, 1'b0, 32'h0,  4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0,  1'b0};

    reset_n = 1'b0;
    drive(1'b0, 2'd0, 1'b0, '0, 4'h0);
    chk("rst_out_val", {60'd0, out_val}, 64'd0);
    chk("rst_out_dom", {60'd0, out_domain}, 64'd0);
    chk("rst_out_msg", {32'd0, out_msg[63:32] | out_msg[31:0] | out_msg[95:64] | out_msg[127:96]}, 64'd0);
    chk("rst_in_rdy", {63'd0, in_rdy}, 64'd1);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[k]) begin
      drive(tbl[k].v, tbl[k].s, tbl[k].d, tbl[k].m, tbl[k].r);
      check_model();
      chk($sformatf("tbl%0d_in_rdy", k), {63'd0, in_rdy}, {63'd0, tbl[k].exp_rdy});
      chk($sformatf("tbl%0d_out_val", k), {60'd0, out_val}, {60'd0, tbl[k].exp_val});
      if (tbl[k].chk_en) begin
        chk($sformatf("tbl%0d_msg", k), {32'd0, sl(int'(tbl[k].chk_i))}, {32'd0, tbl[k].exp_msg});
        chk($sformatf("tbl%0d_dom", k), {63'd0, out_domain[tbl[k].chk_i]}, {63'd0, tbl[k].exp_dom});
      end
      tick();
    end

    // back-to-back stream to output 1, alternating domain, no bubbles
    for (int k = 0; k < 9; k++) begin
      drive(k < 8, 2'd1, 1'(k % 2), NB'(32'h100 + k), 4'hF);
      check_model();
      chk("b2b_in_rdy", {63'd0, in_rdy}, 64'd1);
      if (k > 0) begin
        chk("b2b_val", {63'd0, out_val[1]}, 64'd1);
        chk("b2b_msg", {32'd0, sl(1)}, 64'(32'h100 + k - 1));
        chk("b2b_dom", {63'd0, out_domain[1]}, 64'((k - 1) % 2));
      end
      tick();
    end

    // deq and enq on the same full buffer in one cycle
    drive(1'b1, 2'd1, 1'b0, 32'h5, 4'h0); check_model(); tick();
    drive(1'b1, 2'd1, 1'b1, 32'h6, 4'b0010); check_model();
    chk("dq_enq_rdy", {63'd0, in_rdy}, 64'd1);
    chk("dq_enq_old", {32'd0, sl(1)}, 64'h5);
    tick();
    drive(1'b0, 2'd1, 1'b0, '0, 4'h0); check_model();
    chk("dq_enq_val", {63'd0, out_val[1]}, 64'd1);
    chk("dq_enq_new", {32'd0, sl(1)}, 64'h6);
    chk("dq_enq_dom", {63'd0, out_domain[1]}, 64'd1);

    // fill all four with outputs stalled: input blocked for every select
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 1'b1, NB'(32'h700 + i), 4'h0); check_model(); tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'(i), 1'b0, '0, 4'h0);
      chk($sformatf("allfull_rdy%0d", i), {63'd0, in_rdy}, 64'd0);
    end
    drive(1'b0, 2'd0, 1'b0, '0, 4'hF); check_model(); tick();

    // mid-operation reset with outputs 0 and 3 occupied
    drive(1'b1, 2'd0, 1'b1, 32'h55, 4'h0); check_model(); tick();
    drive(1'b1, 2'd3, 1'b1, 32'h66, 4'h0); check_model(); tick();
    chk("pre_rst_val", {60'd0, out_val}, 64'b1001);
    drive(1'b1, 2'd0, 1'b1, 32'h77, 4'h0);
    reset_n = 1'b0;
    #1;
    pend.delete();
    chk("mid_rst_val", {60'd0, out_val}, 64'd0);
    chk("mid_rst_msg", {32'd0, sl(0) | sl(3)}, 64'd0);
    chk("mid_rst_dom", {60'd0, out_domain}, 64'd0);
    chk("mid_rst_rdy", {63'd0, in_rdy}, 64'd1);
    tick();
    chk("rst_no_enq", {60'd0, out_val}, 64'd0);
    reset_n = 1'b1;
    drive(1'b1, 2'd3, 1'b1, 32'h99, 4'hF); check_model(); tick();
    drive(1'b0, 2'd0, 1'b0, '0, 4'hF); check_model();
    chk("post_rst_val", {60'd0, out_val}, 64'b1000);
    chk("post_rst_msg", {32'd0, sl(3)}, 64'h99);
    tick();

    // drain of a high-domain payload on output 2
    drive(1'b1, 2'd2, 1'b1, 32'hDEADBEEF, 4'h0); check_model(); tick();
    drive(1'b0, 2'd0, 1'b0, '0, 4'b0100); check_model();
    chk("drain_val_pre", {63'd0, out_val[2]}, 64'd1);
    tick();
    drive(1'b0, 2'd0, 1'b0, '0, 4'h0);
    chk("drain_val", {63'd0, out_val[2]}, 64'd0);
`ifdef VC_DEMUX_SCRUB_EN
    chk("scrub_msg", {32'd0, sl(2)}, 64'd0);
    chk("scrub_dom", {63'd0, out_domain[2]}, 64'd0);
`else
    chk("hold_msg", {32'd0, sl(2)}, 64'hDEADBEEF);
    chk("hold_dom", {63'd0, out_domain[2]}, 64'd1);
`endif
    tick();

    // randomized traffic against the reference list
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            NB'($urandom), 4'($urandom_range(0, 15)));
      check_model();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
